// File: rtl/dht_sensor_reader.sv
// dht_sensor_reader: single-wire host controller for a DHT-class humidity/temperature sensor.
// Periodically pulls the line low to request a reading, decodes the 40-bit reply by
// high-pulse width, checks the checksum and presents {hum_int, hum_dec, tmp_int, tmp_dec}
// to the downstream PIO.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   dht_in        raw sensor line level (asynchronous to clk)
//   dht_oe        1 = pad drives the line low, 0 = line released (external pull-up)
//   data_out      last reading that passed its checksum
//   data_valid    set after the first good reading, held until reset
//   sample_strobe one-cycle pulse coincident with a data_out update
//   checksum_err  outcome of the last completed frame
//   timeout_err   outcome of the last transaction
//   busy          high whenever the controller is not idle
module dht_sensor_reader #(
  parameter int unsigned CLK_PER_US     = 50,
  parameter int unsigned POLL_PERIOD_US = 2000000,
  parameter int unsigned START_LOW_US   = 18000,
  parameter int unsigned BIT_THRESH_US  = 40,
  parameter int unsigned TIMEOUT_US     = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        sample_strobe,
  output logic        checksum_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned TickW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(CLK_PER_US - 1);
  localparam logic [23:0] PhaseMax  = '1;
  localparam logic [23:0] PollPh    = 24'(POLL_PERIOD_US);
  localparam logic [23:0] StartPh   = 24'(START_LOW_US);
  localparam logic [23:0] ThreshPh  = 24'(BIT_THRESH_US);
  localparam logic [23:0] TimeoutPh = 24'(TIMEOUT_US);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitAck,
    StAckLow,
    StAckHigh,
    StBitLow,
    StBitHigh,
    StCheck
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [23:0]       phase_q, phase_d, phase_now;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [39:0]       shift_q, shift_d;
  logic              us_tick, line_fall, line_rise, expired, timeout_set, state_enter;
  logic [7:0]        byte_sum;
  logic              csum_ok;

  // sync_q[1] is the synchronized level, sync_q[2] its one-cycle delayed copy.
  assign line_fall = sync_q[2] & ~sync_q[1];
  assign line_rise = ~sync_q[2] & sync_q[1];

  always_comb begin
    us_tick     = (tick_q == TickLast);
    // Count as it stands after this cycle's tick, so a wait of N us lasts exactly
    // N*CLK_PER_US cycles and a measured pulse width equals its true width.
    phase_now   = (us_tick && (phase_q != PhaseMax)) ? phase_q + 24'd1 : phase_q;
    expired     = (phase_now >= TimeoutPh);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    timeout_set = 1'b0;

    unique case (state_q)
      StIdle:  if (phase_now == PollPh) state_d = StStart;
      StStart: if (phase_now == StartPh) state_d = StWaitAck;
      StWaitAck: begin
        if (line_fall) begin
          state_d = StAckLow;
        end else if (expired) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StAckLow: begin
        if (line_rise) begin
          state_d = StAckHigh;
        end else if (expired) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StAckHigh: begin
        if (line_fall) begin
          state_d   = StBitLow;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (expired) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StBitLow: begin
        if (line_rise) begin
          state_d = StBitHigh;
        end else if (expired) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StBitHigh: begin
        // Edge wins over a coincident timeout: the edge branch is tested first.
        if (line_fall) begin
          shift_d   = {shift_q[38:0], (phase_now > ThreshPh)};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? StCheck : StBitLow;
        end else if (expired) begin
          state_d     = StIdle;
          timeout_set = 1'b1;
        end
      end
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    state_enter = (state_d != state_q);
    phase_d     = state_enter ? '0 : phase_now;
    tick_d      = (state_enter || us_tick) ? '0 : tick_q + TickW'(1);

    byte_sum = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    csum_ok  = (byte_sum == shift_q[7:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sync_q    <= '1;
      tick_q    <= '0;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], dht_in};
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Outputs are registered from the next state so they change together with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dht_oe        <= 1'b0;
      busy          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      sample_strobe <= 1'b0;
      checksum_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      dht_oe        <= (state_d == StStart);
      busy          <= (state_d != StIdle);
      sample_strobe <= 1'b0;
      if (state_q == StCheck) begin
        timeout_err <= 1'b0;
        if (csum_ok) begin
          data_out      <= shift_q[39:8];
          data_valid    <= 1'b1;
          sample_strobe <= 1'b1;
          checksum_err  <= 1'b0;
        end else begin
          checksum_err  <= 1'b1;
        end
      end
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht_sensor_reader.sv
// tb_dht_sensor_reader: drives a behavioural DHT sensor on the shared line and checks every
// transaction outcome against a scoreboard of expected results.
module tb_dht_sensor_reader;

  localparam int unsigned Poll     = 100;
  localparam int unsigned StartLow = 18;
  localparam int unsigned Timeout  = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sens = 1'b1;
  logic        dht_in;
  logic        dht_oe;
  logic [31:0] data_out;
  logic        data_valid, sample_strobe, checksum_err, timeout_err, busy;

  // Open-drain line: host pulls low when dht_oe, otherwise the sensor model sets the level.
  assign dht_in = dht_oe ? 1'b0 : sens;

  always #5 clk = ~clk;

  dht_sensor_reader #(
    .CLK_PER_US    (1),
    .POLL_PERIOD_US(Poll),
    .START_LOW_US  (StartLow),
    .BIT_THRESH_US (40),
    .TIMEOUT_US    (Timeout)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dht_in       (dht_in),
    .dht_oe       (dht_oe),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sample_strobe(sample_strobe),
    .checksum_err (checksum_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        ck;
    logic        to;
    int          strobes;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0, m_ck = 1'b0, m_to = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        busy_prev = 1'b0;
  int          strobe_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int strobes);
    exp_t e;
    e.data = m_data; e.valid = m_valid; e.ck = m_ck; e.to = m_to; e.strobes = strobes;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] byte_sum(input logic [31:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

  task automatic expect_frame(input logic [39:0] f);
    m_to = 1'b0;
    if (byte_sum(f[39:8]) == f[7:0]) begin
      m_data = f[39:8]; m_valid = 1'b1; m_ck = 1'b0;
      push_exp(1);
    end else begin
      m_ck = 1'b1;
      push_exp(0);
    end
  endtask

  task automatic wait_oe(input logic lvl, input string tag);
    int k = 0;
    while (dht_oe !== lvl && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (dht_oe !== lvl) check_val(tag, 32'(dht_oe), 32'(lvl));
  endtask

  task automatic wait_start();
    wait_oe(1'b1, "start_rise");
    wait_oe(1'b0, "start_fall");
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (busy) check_val("busy_drop", 32'(busy), 32'd0);
  endtask

  // Release reset and time the idle gap and the start pulse; returns once dht_oe has fallen.
  task automatic release_measure();
    int n = 0;
    int w = 0;
    @(negedge clk);
    reset_n = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!dht_oe && n < 500);
    check_val("idle_gap", 32'(n), 32'(Poll));
    do begin @(posedge clk); #1; w++; end while (dht_oe && w < 500);
    check_val("start_width", 32'(w), 32'(StartLow));
    @(negedge clk);
  endtask

  task automatic abort_reset();
    m_data = '0; m_valid = 1'b0; m_ck = 1'b0; m_to = 1'b0;
    push_exp(0);
    #2 reset_n = 1'b0;
    #1;
    check_val("reset_oe", 32'(dht_oe), 32'd0);
    check_val("reset_outs", {data_out[31:5], data_valid, sample_strobe, checksum_err,
                             timeout_err, busy}, 32'd0);
    repeat (3) @(negedge clk);
    sens = 1'b1;
    release_measure();
  endtask

  // Sensor reply; call at the negedge after the host released the line.
  task automatic send_frame(input logic [39:0] f, input int hi0, input int hi1,
                            input int abort_bit);
    if (abort_bit < 0) expect_frame(f);
    repeat (30) @(negedge clk);
    sens = 1'b0; repeat (80) @(negedge clk);
    sens = 1'b1; repeat (80) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      sens = 1'b0; repeat (50) @(negedge clk);
      sens = 1'b1;
      if (i == abort_bit) begin
        repeat (10) @(negedge clk);
        abort_reset();
        return;
      end
      repeat (f[39-i] ? hi1 : hi0) @(negedge clk);
    end
    sens = 1'b0; repeat (50) @(negedge clk);
    sens = 1'b1;
    wait_idle();
  endtask

  // Scoreboard: each end of a transaction (busy falling) retires one expectation.
  always @(negedge clk) begin
    if (sample_strobe) strobe_cnt++;
    if (busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_txn", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("data_out", data_out, mon_e.data);
        check_val("data_valid", 32'(data_valid), 32'(mon_e.valid));
        check_val("checksum_err", 32'(checksum_err), 32'(mon_e.ck));
        check_val("timeout_err", 32'(timeout_err), 32'(mon_e.to));
        check_val("strobes", 32'(strobe_cnt), 32'(mon_e.strobes));
      end
      strobe_cnt = 0;
    end
    busy_prev = busy;
  end

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {data_out[31:6], dht_oe, data_valid, sample_strobe, checksum_err,
                           timeout_err, busy}, 32'd0);
    check_val("rst_data", data_out, 32'd0);

    // 1: good frame after reset
    release_measure();
    send_frame(40'h37_00_19_05_55, 27, 70, -1);

    // 2: bad checksum
    wait_start();
    send_frame(40'h37_00_19_05_56, 27, 70, -1);

    // 3: no acknowledge, then a good frame
    wait_start();
    m_to = 1'b1;
    push_exp(0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 500);
    check_val("timeout_len", 32'(n), 32'(Timeout));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dht_oe && n < 500);
    check_val("retry_gap", 32'(n), 32'(Poll));
    @(negedge clk);
    wait_start();
    send_frame(40'h12_34_56_78_14, 27, 70, -1);

    // 4: checksum wrap-around
    wait_start();
    send_frame(40'hFF_FF_01_02_01, 27, 70, -1);

    // 5: threshold boundary widths
    wait_start();
    send_frame(40'hA5_3C_0F_F0_E0, 40, 41, -1);

    // 6a: reset during bit 20, then a clean transaction
    wait_start();
    send_frame(40'h37_00_19_05_55, 27, 70, 19);
    send_frame(40'h37_00_19_05_55, 27, 70, -1);

    // 6b: reset during the start pulse, then a clean transaction
    wait_oe(1'b1, "start_rise_6b");
    repeat (5) @(negedge clk);
    abort_reset();
    send_frame(40'h12_34_56_78_14, 27, 70, -1);

    repeat (5) @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dht_sensor_reader.md
Name: dht_sensor_reader

Overview:
- Single-wire host controller for the greenhouse DHT-class temperature/humidity sensor.
- Periodically issues the start pulse, decodes the 40-bit sensor frame, and verifies the checksum.
- Presents a 32-bit word {hum_int, hum_dec, tmp_int, tmp_dec} that drives the in_port of the temperature/humidity PIO read by the Nios II.
- Sits directly upstream of that PIO, between the sensor pin and the Avalon fabric.

Parameters:
- CLK_PER_US, 50, clk cycles per microsecond; drives the internal 1 us tick.
- POLL_PERIOD_US, 2000000, idle time in us between end of one transaction and next start pulse.
- START_LOW_US, 18000, duration in us the host drives the line low.
- BIT_THRESH_US, 40, high-pulse width threshold: width > threshold decodes 1, width <= threshold decodes 0.
- TIMEOUT_US, 200, maximum us allowed in any wait-for-edge state.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dht_in  in  1  raw sensor line level (from tristate pad, asynchronous)
- dht_oe  out  1  1 = pad drives line low; 0 = released (pulled high externally)
- data_out  out  32  last good reading {hum_int, hum_dec, tmp_int, tmp_dec}
- data_valid  out  1  set after first good reading, held until reset
- sample_strobe  out  1  one-cycle pulse when data_out updates
- checksum_err  out  1  result of last completed frame
- timeout_err  out  1  result of last transaction
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: clk is the clock; reset_n is asynchronous, active-low.
  - While reset_n is low, all outputs are 0 (dht_oe=0, so the line is released immediately) and state is IDLE.
  - Counters and the shift register are cleared.
  - Reset mid-transaction aborts it; the next start is issued POLL_PERIOD_US after release.
- Input sync: dht_in passes through a 2-FF synchronizer. All edge detection uses the synchronized value and its 1-cycle delayed copy.
- Timebase:
  - us_tick pulses once every CLK_PER_US cycles.
  - phase_us is a 24-bit counter, cleared on every state entry and incremented on us_tick, saturating at max.
- FSM states and transitions:
  - IDLE: dht_oe=0. When phase_us == POLL_PERIOD_US, go to START.
  - START: dht_oe=1. When phase_us == START_LOW_US, go to WAIT_ACK.
  - WAIT_ACK: dht_oe=0. Falling edge -> ACK_LOW.
  - ACK_LOW: rising edge -> ACK_HIGH.
  - ACK_HIGH: falling edge -> BIT_LOW; clear bit_cnt (6 bits) and shift register (40 bits).
  - BIT_LOW: rising edge -> BIT_HIGH.
  - BIT_HIGH: on falling edge:
    - Shift in (phase_us > BIT_THRESH_US), MSB first; bit_cnt++.
    - If bit_cnt reaches 40 -> CHECK, else -> BIT_LOW.
  - CHECK: lasts one cycle, then -> IDLE.
- Timeout: in WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW and BIT_HIGH, phase_us reaching TIMEOUT_US before the expected edge causes:
  - timeout_err=1, checksum_err unchanged;
  - data_out and data_valid unchanged, no strobe;
  - transition to IDLE.
- CHECK actions, with the frame taken as bytes b0..b4 (b0 received first):
  - Checksum: (b0+b1+b2+b3) mod 256 == b4, using 8-bit wrap-around addition.
  - Pass: data_out <= {b0,b1,b2,b3}, data_valid <= 1, sample_strobe=1 for this cycle only, checksum_err <= 0, timeout_err <= 0.
  - Fail: checksum_err <= 1, timeout_err <= 0, data_out held.
- Output latency: data_out updates 1 cycle after the synchronized falling edge that ends bit 40, i.e. about 3 clk after the pin edge.
- Edge case: an edge coincident with timeout expiry resolves as the edge (not a timeout).
- Width rules:
  - A pulse of exactly BIT_THRESH_US decodes 0.
  - Bits beyond 40 are never sampled, because the FSM has already left BIT_HIGH.
- busy is registered and equals (state != IDLE).

Test Plan:
- All tests use CLK_PER_US=1, POLL_PERIOD_US=100, START_LOW_US=18, BIT_THRESH_US=40, TIMEOUT_US=200.
1. Reset, release; sensor model sends frame 0x37_00_19_05_55 with 80/80 us ack, bit high 27 us (0) or 70 us (1) -> dht_oe high exactly 18 us after 100 us idle; data_out=0x37001905, data_valid=1, one sample_strobe, both errs 0.
2. Same frame with checksum byte 0x56 -> checksum_err=1, data_out keeps previous value (0 if first), no strobe, data_valid unchanged.
3. Sensor never acks after start -> after 200 us in WAIT_ACK: timeout_err=1, busy=0, next start 100 us later; a following good frame clears timeout_err.
4. Checksum wrap: bytes 0xFF,0xFF,0x01,0x02, checksum 0x01 -> accepted, data_out=0xFFFF0102.
5. Boundary widths: bit highs of 40 us and 41 us -> decode 0 and 1 respectively.
6. Assert reset_n low during bit 20 while dht_oe=0, and separately during START -> dht_oe=0 asynchronously, all outputs 0, clean good transaction after release.
